// File: rtl/riscv_test_pkg.sv
// Shared definitions for the riscv-tests end-of-test monitor.
// Holds the MODE constants, the monitor FSM states and the result decoder.
// Purely combinational content: no latency and no backpressure apply.
package riscv_test_pkg;

  localparam int MODE_PC     = 0;
  localparam int MODE_TOHOST = 1;
  localparam int MODE_BOTH   = 2;

  // Decoder works on a fixed maximum width; callers zero-extend and slice.
  localparam int DEC_W = 64;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic             pass;
    logic [DEC_W-2:0] test_num;
  } decode_t;

  // riscv-tests convention: result 1 means pass, otherwise value>>1 is the
  // number of the failing test case.
  function automatic decode_t decode_result(input logic [DEC_W-1:0] value);
    decode_t r;
    r.pass     = (value == DEC_W'(1));
    r.test_num = r.pass ? '0 : value[DEC_W-1:1];
    return r;
  endfunction

endpackage

// File: rtl/rt_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Latency: q reflects en/clr one cycle later. No backpressure.
// Ports: clk, rst (sync, active-high), en (count), clr (zero, wins over en), q.
module rt_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests: watches fetch PC and stores, decodes pass/fail/timeout.
// Latency: done/pass/fail/timeout rise the cycle after the deciding cycle; all sticky until rst.
// No backpressure: pure observer, never stalls the core.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_valid, pc, gp    fetch qualifier, fetch PC, architectural x3
//   st_valid, st_addr,  committed data store and its byte address/data
//   st_data
//   done/pass/fail/     sticky result flags (exactly one of pass/fail/timeout with done)
//   timeout
//   test_num            failing test number (result>>1), 0 on pass/timeout
//   cycles              RUN cycle count, frozen once done
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] PASS_PC    = 'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
  parameter int             MODE        = 2,
  parameter int             TIMEOUT     = 6000,
  parameter int             ARM_DELAY   = 2,
  parameter int             CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  gp,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  test_num,
  output logic [CNT_W-1:0] cycles
);

  // ARM_DELAY of 0 behaves like 1: ARM is the reset state and is left at the
  // first clock edge after reset release.
  localparam int ARM_LAST = (ARM_DELAY == 0) ? 0 : ARM_DELAY - 1;
  localparam int TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic PC_EN   = (MODE == MODE_PC)     || (MODE == MODE_BOTH);
  localparam logic HOST_EN = (MODE == MODE_TOHOST) || (MODE == MODE_BOTH);
  localparam logic TO_EN   = (TIMEOUT != 0);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   pass_q, pass_d;
  logic   fail_q, fail_d;
  logic   timeout_q, timeout_d;
  logic [XLEN-2:0] test_num_q, test_num_d;

  logic [CNT_W-1:0] arm_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             cyc_en;

  logic            pc_evt;
  logic            host_evt;
  logic [XLEN-1:0] evt_value;
  logic            to_hit;
  decode_t         dec;
  logic            unused_dec;

  rt_sat_counter #(.CNT_W(CNT_W)) u_arm_cnt (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_ARM),
    .clr (state_q != ST_ARM),
    .q   (arm_cnt)
  );

  // Counts only while RUN continues, so the deciding cycle's count is what
  // stays visible in DONE.
  rt_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cyc_en),
    .clr (state_q == ST_ARM),
    .q   (cyc_cnt)
  );

  assign pc_evt   = PC_EN && pc_valid && (pc == PASS_PC);
  // A tohost write with bit 0 clear is a syscall-style message, not an exit.
  assign host_evt = HOST_EN && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  // tohost carries the authoritative result when both fire together.
  assign evt_value = host_evt ? st_data : gp;
  assign to_hit    = TO_EN && (cyc_cnt == CNT_W'(TO_LAST));

  assign dec        = decode_result(DEC_W'(evt_value));
  assign unused_dec = ^dec.test_num[DEC_W-2:XLEN-1];

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    test_num_d = test_num_q;
    cyc_en     = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (arm_cnt == CNT_W'(ARM_LAST)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pc_evt || host_evt) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          pass_d     = dec.pass;
          fail_d     = !dec.pass;
          test_num_d = dec.test_num[XLEN-2:0];
        end else if (to_hit) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cyc_en = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARM;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      test_num_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      test_num_q <= test_num_d;
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign test_num = test_num_q;
  assign cycles   = cyc_cnt;

endmodule
